pomdp_episode_ctrl: RTL and testbench
=====================================

POMDP_EPISODE_CTRL -- requirements
Module: pomdp_episode_ctrl

Interface
REQ-001 SHALL have parameter NS, default 2, number of hidden states (2..16).
REQ-002 SHALL have parameter NA, default 3, number of actions (2..16).
REQ-003 SHALL have parameter NO, default 2, number of observations (2..16).
REQ-004 SHALL have parameter BW, default 16, belief element width, unsigned fixed point.
REQ-005 SHALL have parameter RW, default 32, accumulated reward width, signed.
REQ-006 SHALL have parameter SW, default 16, step counter width.
REQ-007 SHALL define derived widths SB=$clog2(NS), AB=$clog2(NA), OB=$clog2(NO), each at least 1.
REQ-008 SHALL have port clk, input, 1 bit: the only clock; all logic on its rising edge.
REQ-009 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-010 SHALL have port start, input, 1 bit: start-episode pulse; sampled only in IDLE.
REQ-011 SHALL have port abort, input, 1 bit: terminate the running episode.
REQ-012 SHALL have port num_steps, input, SW bits: episode horizon; sampled with start.
REQ-013 SHALL have port init_state, input, SB bits: initial hidden state; sampled with start.
REQ-014 SHALL have port init_belief, input, NS*BW bits: flattened initial belief, element i at bits [i*BW +: BW]; sampled with start.
REQ-015 SHALL have decision handshake ports: dec_req output 1; dec_belief output NS*BW; dec_ack input 1; dec_action input AB.
REQ-016 SHALL have environment handshake ports: env_req output 1; env_state output SB; env_action output AB; env_ack input 1; env_new_state input SB; env_obs input OB; env_reward input 16, signed.
REQ-017 SHALL have belief handshake ports: bel_req output 1; bel_belief output NS*BW; bel_action output AB; bel_obs output OB; bel_ack input 1; bel_new_belief input NS*BW.
REQ-018 SHALL have status ports: busy output 1; done output 1 (pulse); aborted output 1; step_valid output 1 (pulse).
REQ-019 SHALL have data ports: step_cnt output SW; cur_state output SB; action output AB; observation output OB; total_reward output RW, signed.

Function
REQ-020 SHALL implement FSM states IDLE, DECIDE, ENV, BELIEF, STEP, FIN.
REQ-021 IDLE with start=1 and num_steps>0 SHALL capture all start-sampled inputs, clear step_cnt and total_reward, and go to DECIDE.
REQ-022 IDLE with start=1 and num_steps=0 SHALL clear step_cnt and total_reward and go to FIN without issuing any request.
REQ-023 Handshake rule, all three channels: req SHALL be asserted in the first cycle of its state and held until the cycle ack=1; req SHALL deassert in the following cycle; ack while req=0 SHALL be ignored.
REQ-024 DECIDE SHALL drive dec_belief=current belief; on dec_ack it SHALL register action<=dec_action and go to ENV.
REQ-025 ENV SHALL drive env_state=cur_state and env_action=action; on env_ack it SHALL register env_new_state (pending), observation<=env_obs, add sign-extended env_reward to total_reward, and go to BELIEF.
REQ-026 Reward accumulation SHALL saturate at the RW-bit signed max/min and never wrap.
REQ-027 BELIEF SHALL drive bel_belief=current belief, bel_action=action, bel_obs=observation; on bel_ack it SHALL register current belief<=bel_new_belief, cur_state<=pending state, and go to STEP.
REQ-028 STEP SHALL pulse step_valid for 1 cycle and increment step_cnt; if the new step_cnt equals the captured num_steps it SHALL go to FIN, else to DECIDE.
REQ-029 FIN SHALL pulse done for 1 cycle and return to IDLE; total_reward, step_cnt, cur_state, action and observation SHALL hold until the next start.
REQ-030 busy SHALL be 1 in every state except IDLE.
REQ-031 start while busy SHALL be ignored.
REQ-032 abort=1 in DECIDE/ENV/BELIEF/STEP SHALL drop all req next cycle, set aborted=1, and go to FIN; an ack in the same cycle as abort SHALL be discarded.
REQ-033 aborted SHALL hold until the next accepted start, which SHALL clear it.
REQ-034 abort in IDLE or FIN SHALL have no effect.
REQ-035 Minimum step latency with same-cycle acks SHALL be 4 cycles (DECIDE, ENV, BELIEF, STEP); done SHALL occur 1 cycle after the last step_valid.
REQ-036 step_cnt SHALL not wrap; num_steps=2^SW-1 SHALL be a legal horizon.

Reset
REQ-037 rst_n=0 SHALL asynchronously force IDLE and set all req, busy, done, aborted, step_valid, step_cnt, cur_state, action, observation, total_reward and current belief to 0.
REQ-038 Reset asserted mid-episode SHALL abandon the episode without a done pulse; after release the block SHALL wait in IDLE for start.

Verification
REQ-039 NS=2, num_steps=3, every ack returned 1 cycle after req, env_reward=+5 -> three step_valid pulses, done pulse, total_reward=15, step_cnt=3, aborted=0.
REQ-040 start with num_steps=0 -> done 1 cycle after FIN entry, no req asserted, total_reward=0.
REQ-041 RW=8, env_reward=+100 each step, num_steps=2 -> total_reward=127 (saturated); env_reward=-100 -> total_reward=-128.
REQ-042 abort while env_req is high and env_ack=1 in the same cycle -> reward unchanged, aborted=1, done pulses, bel_req never asserted.
REQ-043 Delay dec_ack by 10 cycles -> dec_req held for 11 cycles, dec_belief stable throughout; start pulsed mid-episode -> ignored.
REQ-044 Assert rst_n=0 during BELIEF -> all outputs 0 immediately, no done pulse; a later start runs a clean episode.

Source files
------------

// File: rtl/pomdp_episode_ctrl.sv
// Episode sequencer for a POMDP agent loop: decide -> environment step -> belief update,
// repeated for a fixed horizon, with saturating reward accumulation and abort.
module pomdp_episode_ctrl #(
  parameter int NS = 2,
  parameter int NA = 3,
  parameter int NO = 2,
  parameter int BW = 16,
  parameter int RW = 32,
  parameter int SW = 16,
  localparam int SB = (NS > 1) ? $clog2(NS) : 1,
  localparam int AB = (NA > 1) ? $clog2(NA) : 1,
  localparam int OB = (NO > 1) ? $clog2(NO) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic [SW-1:0]        num_steps,
  input  logic [SB-1:0]        init_state,
  input  logic [NS*BW-1:0]     init_belief,
  output logic                 dec_req,
  output logic [NS*BW-1:0]     dec_belief,
  input  logic                 dec_ack,
  input  logic [AB-1:0]        dec_action,
  output logic                 env_req,
  output logic [SB-1:0]        env_state,
  output logic [AB-1:0]        env_action,
  input  logic                 env_ack,
  input  logic [SB-1:0]        env_new_state,
  input  logic [OB-1:0]        env_obs,
  input  logic signed [15:0]   env_reward,
  output logic                 bel_req,
  output logic [NS*BW-1:0]     bel_belief,
  output logic [AB-1:0]        bel_action,
  output logic [OB-1:0]        bel_obs,
  input  logic                 bel_ack,
  input  logic [NS*BW-1:0]     bel_new_belief,
  output logic                 busy,
  output logic                 done,
  output logic                 aborted,
  output logic                 step_valid,
  output logic [SW-1:0]        step_cnt,
  output logic [SB-1:0]        cur_state,
  output logic [AB-1:0]        action,
  output logic [OB-1:0]        observation,
  output logic signed [RW-1:0] total_reward
);

  // Reward sum is formed one bit wider than both operands so overflow is detectable.
  localparam int XW = ((RW > 16) ? RW : 16) + 1;
  localparam logic signed [XW-1:0] SAT_HI = {{(XW-RW+1){1'b0}}, {(RW-1){1'b1}}};
  localparam logic signed [XW-1:0] SAT_LO = {{(XW-RW+1){1'b1}}, {(RW-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_DECIDE,
    S_ENV,
    S_BELIEF,
    S_STEP,
    S_FIN
  } state_t;

  state_t r_state;
  state_t w_next;

  logic                 w_dec_req;
  logic                 w_env_req;
  logic                 w_bel_req;
  logic                 w_start_take;
  logic                 w_abort_take;
  logic                 w_dec_take;
  logic                 w_env_take;
  logic                 w_bel_take;
  logic                 w_step_take;
  logic                 w_last_step;
  logic [SW-1:0]        w_cnt_inc;
  logic signed [XW-1:0] w_sum;
  logic signed [RW-1:0] w_total_sat;

  logic                 r_done;
  logic                 r_aborted;
  logic                 r_step_valid;
  logic [SW-1:0]        r_num_steps;
  logic [SW-1:0]        r_step_cnt;
  logic [SB-1:0]        r_cur_state;
  logic [SB-1:0]        r_pend_state;
  logic [AB-1:0]        r_action;
  logic [OB-1:0]        r_obs;
  logic signed [RW-1:0] r_total;
  logic [NS*BW-1:0]     r_belief;

  assign w_cnt_inc   = r_step_cnt + SW'(1);
  assign w_last_step = (w_cnt_inc == r_num_steps);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Abort takes priority over any ack arriving in the same cycle.
  always_comb begin
    w_next       = r_state;
    w_dec_req    = 1'b0;
    w_env_req    = 1'b0;
    w_bel_req    = 1'b0;
    w_start_take = 1'b0;
    w_abort_take = 1'b0;
    w_dec_take   = 1'b0;
    w_env_take   = 1'b0;
    w_bel_take   = 1'b0;
    w_step_take  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_start_take = 1'b1;
          w_next       = (num_steps == '0) ? S_FIN : S_DECIDE;
        end
      end
      S_DECIDE: begin
        w_dec_req = 1'b1;
        if (abort) begin
          w_abort_take = 1'b1;
          w_next       = S_FIN;
        end else if (dec_ack) begin
          w_dec_take = 1'b1;
          w_next     = S_ENV;
        end
      end
      S_ENV: begin
        w_env_req = 1'b1;
        if (abort) begin
          w_abort_take = 1'b1;
          w_next       = S_FIN;
        end else if (env_ack) begin
          w_env_take = 1'b1;
          w_next     = S_BELIEF;
        end
      end
      S_BELIEF: begin
        w_bel_req = 1'b1;
        if (abort) begin
          w_abort_take = 1'b1;
          w_next       = S_FIN;
        end else if (bel_ack) begin
          w_bel_take = 1'b1;
          w_next     = S_STEP;
        end
      end
      S_STEP: begin
        if (abort) begin
          w_abort_take = 1'b1;
          w_next       = S_FIN;
        end else begin
          w_step_take = 1'b1;
          w_next      = w_last_step ? S_FIN : S_DECIDE;
        end
      end
      S_FIN: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  assign w_sum = $signed({{(XW-RW){r_total[RW-1]}}, r_total})
               + $signed({{(XW-16){env_reward[15]}}, env_reward});

  always_comb begin
    w_total_sat = w_sum[RW-1:0];
    if (w_sum > SAT_HI) begin
      w_total_sat = {1'b0, {(RW-1){1'b1}}};
    end else if (w_sum < SAT_LO) begin
      w_total_sat = {1'b1, {(RW-1){1'b0}}};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_done       <= 1'b0;
      r_aborted    <= 1'b0;
      r_step_valid <= 1'b0;
      r_num_steps  <= '0;
      r_step_cnt   <= '0;
      r_cur_state  <= '0;
      r_pend_state <= '0;
      r_action     <= '0;
      r_obs        <= '0;
      r_total      <= '0;
      r_belief     <= '0;
    end else begin
      r_done       <= (r_state == S_FIN);
      r_step_valid <= w_step_take;
      if (w_start_take) begin
        r_step_cnt <= '0;
        r_total    <= '0;
        r_aborted  <= 1'b0;
        if (num_steps != '0) begin
          r_num_steps <= num_steps;
          r_cur_state <= init_state;
          r_belief    <= init_belief;
        end
      end
      if (w_abort_take) begin
        r_aborted <= 1'b1;
      end
      if (w_dec_take) begin
        r_action <= dec_action;
      end
      if (w_env_take) begin
        r_pend_state <= env_new_state;
        r_obs        <= env_obs;
        r_total      <= w_total_sat;
      end
      if (w_bel_take) begin
        r_belief    <= bel_new_belief;
        r_cur_state <= r_pend_state;
      end
      // The captured horizon is never zero here, so the increment cannot wrap.
      if (w_step_take) begin
        r_step_cnt <= w_cnt_inc;
      end
    end
  end

  assign dec_req      = w_dec_req;
  assign dec_belief   = r_belief;
  assign env_req      = w_env_req;
  assign env_state    = r_cur_state;
  assign env_action   = r_action;
  assign bel_req      = w_bel_req;
  assign bel_belief   = r_belief;
  assign bel_action   = r_action;
  assign bel_obs      = r_obs;
  assign busy         = (r_state != S_IDLE);
  assign done         = r_done;
  assign aborted      = r_aborted;
  assign step_valid   = r_step_valid;
  assign step_cnt     = r_step_cnt;
  assign cur_state    = r_cur_state;
  assign action       = r_action;
  assign observation  = r_obs;
  assign total_reward = r_total;

endmodule

// File: tb/tb_pomdp_episode_ctrl.sv
// Scoreboard bench for pomdp_episode_ctrl: a responder plays decision/env/belief agents and
// feeds an episode-level model; a monitor checks every step_valid and done against it.
module tb_pomdp_episode_ctrl;
  localparam int NS   = 2;
  localparam int NA   = 3;
  localparam int NO   = 2;
  localparam int BW   = 16;
  localparam int RW   = 8;
  localparam int SW   = 16;
  localparam int SB   = 1;
  localparam int AB   = 2;
  localparam int OB   = 1;
  localparam int BELW = NS*BW;

  logic clk;
  logic rst_n;
  logic start;
  logic abort;
  logic [SW-1:0] num_steps;
  logic [SB-1:0] init_state;
  logic [BELW-1:0] init_belief;
  logic dec_req;
  logic [BELW-1:0] dec_belief;
  logic dec_ack;
  logic [AB-1:0] dec_action;
  logic env_req;
  logic [SB-1:0] env_state;
  logic [AB-1:0] env_action;
  logic env_ack;
  logic [SB-1:0] env_new_state;
  logic [OB-1:0] env_obs;
  logic signed [15:0] env_reward;
  logic bel_req;
  logic [BELW-1:0] bel_belief;
  logic [AB-1:0] bel_action;
  logic [OB-1:0] bel_obs;
  logic bel_ack;
  logic [BELW-1:0] bel_new_belief;
  logic busy;
  logic done;
  logic aborted;
  logic step_valid;
  logic [SW-1:0] step_cnt;
  logic [SB-1:0] cur_state;
  logic [AB-1:0] action;
  logic [OB-1:0] observation;
  logic signed [RW-1:0] total_reward;

  pomdp_episode_ctrl #(
    .NS(NS), .NA(NA), .NO(NO), .BW(BW), .RW(RW), .SW(SW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .num_steps(num_steps), .init_state(init_state), .init_belief(init_belief),
    .dec_req(dec_req), .dec_belief(dec_belief), .dec_ack(dec_ack), .dec_action(dec_action),
    .env_req(env_req), .env_state(env_state), .env_action(env_action), .env_ack(env_ack),
    .env_new_state(env_new_state), .env_obs(env_obs), .env_reward(env_reward),
    .bel_req(bel_req), .bel_belief(bel_belief), .bel_action(bel_action), .bel_obs(bel_obs),
    .bel_ack(bel_ack), .bel_new_belief(bel_new_belief),
    .busy(busy), .done(done), .aborted(aborted), .step_valid(step_valid),
    .step_cnt(step_cnt), .cur_state(cur_state), .action(action),
    .observation(observation), .total_reward(total_reward)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  typedef struct {
    int cnt;
    int st;
    int act;
    int obs;
    int tot;
    logic [BELW-1:0] bel;
  } step_t;

  typedef struct {
    int tot;
    int cnt;
    int ab;
    int n;
  } end_t;

  step_t step_q[$];
  end_t  end_q[$];

  int errs = 0;
  int checks = 0;

  // Episode-level reference model state
  int m_total = 0;
  int m_cnt = 0;
  int m_num = 0;
  int m_state = 0;
  int m_pend = 0;
  int m_action = 0;
  int m_obs = 0;
  logic [BELW-1:0] m_belief = '0;

  int fix_dly = -1;
  int fix_rew_en = 0;
  int fix_rew = 0;
  int abort_at_env = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic int sat_add(input int a, input int b);
    int hi;
    int lo;
    int s;
    hi = (1 << (RW-1)) - 1;
    lo = -(1 << (RW-1));
    s = a + b;
    if (s > hi) s = hi;
    if (s < lo) s = lo;
    return s;
  endfunction

  function automatic int pick_dly();
    if (fix_dly >= 0) return fix_dly;
    return int'($urandom_range(3, 0));
  endfunction

  // Responder: one process serves all three channels, since the controller only
  // ever has one request outstanding.
  initial begin : driver
    int dly;
    bit ok;
    int r;
    dec_ack = 1'b0; env_ack = 1'b0; bel_ack = 1'b0; abort = 1'b0;
    dec_action = '0; env_new_state = '0; env_obs = '0; env_reward = '0;
    bel_new_belief = '0;
    forever begin
      @(negedge clk);
      dec_ack = 1'b0; env_ack = 1'b0; bel_ack = 1'b0; abort = 1'b0;
      if (dec_req) begin
        dly = pick_dly();
        ok = 1'b1;
        for (int i = 0; i < dly; i++) begin
          chk("dec_belief_hold", longint'(dec_belief), longint'(m_belief));
          @(negedge clk);
          if (!dec_req) begin ok = 1'b0; break; end
        end
        if (ok) begin
          chk("dec_belief", longint'(dec_belief), longint'(m_belief));
          dec_action = AB'($urandom_range(NA-1, 0));
          dec_ack = 1'b1;
          m_action = int'(dec_action);
        end
      end else if (env_req) begin
        dly = pick_dly();
        ok = 1'b1;
        for (int i = 0; i < dly; i++) begin
          @(negedge clk);
          if (!env_req) begin ok = 1'b0; break; end
        end
        if (ok) begin
          chk("env_state", longint'(env_state), longint'(m_state));
          chk("env_action", longint'(env_action), longint'(m_action));
          env_new_state = SB'($urandom_range(NS-1, 0));
          env_obs = OB'($urandom_range(NO-1, 0));
          r = fix_rew_en ? fix_rew : int'($urandom_range(200, 0)) - 100;
          env_reward = 16'(r);
          env_ack = 1'b1;
          if (abort_at_env == 1) begin
            abort = 1'b1;
            abort_at_env = 0;
            end_q.push_back('{m_total, m_cnt, 1, m_num});
          end else begin
            if (abort_at_env > 1) abort_at_env--;
            m_pend = int'(env_new_state);
            m_obs = int'(env_obs);
            m_total = sat_add(m_total, r);
          end
        end
      end else if (bel_req) begin
        dly = pick_dly();
        ok = 1'b1;
        for (int i = 0; i < dly; i++) begin
          @(negedge clk);
          if (!bel_req) begin ok = 1'b0; break; end
        end
        if (ok) begin
          chk("bel_belief", longint'(bel_belief), longint'(m_belief));
          chk("bel_action", longint'(bel_action), longint'(m_action));
          chk("bel_obs", longint'(bel_obs), longint'(m_obs));
          bel_new_belief = BELW'({$urandom(), $urandom()});
          bel_ack = 1'b1;
          m_belief = bel_new_belief;
          m_state = m_pend;
          m_cnt++;
          step_q.push_back('{m_cnt, m_state, m_action, m_obs, m_total, m_belief});
          if (m_cnt == m_num) end_q.push_back('{m_total, m_cnt, 0, m_num});
        end
      end else if ($urandom_range(3, 0) == 0) begin
        // Stray acks with no request outstanding must be ignored.
        dec_ack = 1'b1; env_ack = 1'b1; bel_ack = 1'b1;
        dec_action = AB'($urandom_range(NA-1, 0));
        env_reward = 16'($urandom_range(65535, 0));
        bel_new_belief = BELW'({$urandom(), $urandom()});
      end
    end
  end

  initial begin : monitor
    step_t s;
    end_t e;
    int last_sv;
    last_sv = -100;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (step_valid) begin
          last_sv = cyc;
          checks++;
          if (step_q.size() == 0) begin
            errs++;
            $display("FAIL unexpected_step_valid: got step_valid=1 with no step due, expected 0");
          end else begin
            s = step_q.pop_front();
            chk("sv_step_cnt", longint'(step_cnt), longint'(s.cnt));
            chk("sv_cur_state", longint'(cur_state), longint'(s.st));
            chk("sv_action", longint'(action), longint'(s.act));
            chk("sv_observation", longint'(observation), longint'(s.obs));
            chk("sv_total_reward", longint'(total_reward), longint'(s.tot));
            chk("sv_belief", longint'(dec_belief), longint'(s.bel));
          end
        end
        if (done) begin
          checks++;
          if (end_q.size() == 0) begin
            errs++;
            $display("FAIL unexpected_done: got done=1 with no episode ending, expected 0");
          end else begin
            e = end_q.pop_front();
            chk("done_total_reward", longint'(total_reward), longint'(e.tot));
            chk("done_step_cnt", longint'(step_cnt), longint'(e.cnt));
            chk("done_aborted", longint'(aborted), longint'(e.ab));
            if (e.n > 0 && e.ab == 0)
              chk("done_after_last_step", longint'(cyc - last_sv), 1);
          end
        end
      end
    end
  end

  task automatic start_ep(input int n);
    @(negedge clk);
    num_steps = SW'(n);
    init_state = SB'($urandom_range(NS-1, 0));
    init_belief = BELW'({$urandom(), $urandom()});
    start = 1'b1;
    m_total = 0;
    m_cnt = 0;
    m_num = n;
    if (n == 0) begin
      end_q.push_back('{0, 0, 0, 0});
    end else begin
      m_state = int'(init_state);
      m_belief = init_belief;
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int bel_seen);
    bel_seen = 0;
    checks++;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (bel_req) bel_seen++;
      if (done) return;
    end
    errs++;
    $display("FAIL done_timeout: got no done within %0d cycles, expected done", budget);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, longint'(busy), 0);
    chk({tag, "_dec_req"}, longint'(dec_req), 0);
    chk({tag, "_env_req"}, longint'(env_req), 0);
    chk({tag, "_bel_req"}, longint'(bel_req), 0);
    chk({tag, "_done"}, longint'(done), 0);
    chk({tag, "_aborted"}, longint'(aborted), 0);
    chk({tag, "_step_valid"}, longint'(step_valid), 0);
    chk({tag, "_step_cnt"}, longint'(step_cnt), 0);
    chk({tag, "_cur_state"}, longint'(cur_state), 0);
    chk({tag, "_action"}, longint'(action), 0);
    chk({tag, "_observation"}, longint'(observation), 0);
    chk({tag, "_total_reward"}, longint'(total_reward), 0);
    chk({tag, "_belief"}, longint'(dec_belief), 0);
  endtask

  task automatic model_reset();
    m_total = 0; m_cnt = 0; m_num = 0; m_state = 0; m_pend = 0;
    m_action = 0; m_obs = 0; m_belief = '0;
  endtask

  initial begin : main
    int nb;
    int ndec;
    rst_n = 1'b0;
    start = 1'b0;
    num_steps = '0;
    init_state = '0;
    init_belief = '0;
    repeat (2) @(negedge clk);
    chk_zero("reset");
    rst_n = 1'b1;

    // Three steps, acks one cycle after req, reward +5 each
    fix_dly = 1; fix_rew_en = 1; fix_rew = 5;
    start_ep(3);
    wait_done(200, nb);
    chk("basic_total", longint'(total_reward), 15);
    chk("basic_step_cnt", longint'(step_cnt), 3);
    chk("basic_aborted", longint'(aborted), 0);

    // Saturation in an 8-bit accumulator
    fix_dly = -1; fix_rew = 100;
    start_ep(2);
    wait_done(200, nb);
    chk("sat_hi_total", longint'(total_reward), 127);
    fix_rew = -100;
    start_ep(2);
    wait_done(200, nb);
    chk("sat_lo_total", longint'(total_reward), -128);

    // Zero horizon: straight to FIN, done one cycle later, no requests
    start_ep(0);
    chk("zero_done_early", longint'(done), 0);
    chk("zero_reqs_fin", longint'({dec_req, env_req, bel_req}), 0);
    @(negedge clk);
    chk("zero_done", longint'(done), 1);
    chk("zero_reqs_idle", longint'({dec_req, env_req, bel_req}), 0);
    chk("zero_total", longint'(total_reward), 0);

    // Slow decision agent, plus a start pulse while busy
    fix_dly = 10; fix_rew_en = 0;
    start_ep(1);
    ndec = 0;
    for (int i = 0; i < 40; i++) begin
      if (!dec_req) break;
      ndec++;
      if (i == 3) begin
        start = 1'b1;
        num_steps = SW'(5);
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    chk("dec_req_hold_cycles", longint'(ndec), 11);
    wait_done(300, nb);
    chk("busy_start_ignored_cnt", longint'(step_cnt), 1);

    // Abort coinciding with env_ack on the second step
    fix_dly = -1;
    abort_at_env = 2;
    start_ep(3);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (aborted) break;
    end
    chk("abort_flag_set", longint'(aborted), 1);
    chk("abort_env_req_drop", longint'(env_req), 0);
    wait_done(50, nb);
    chk("abort_no_bel_req", longint'(nb), 0);
    chk("abort_flag_hold", longint'(aborted), 1);

    // Reset in the middle of BELIEF
    fix_dly = 4;
    start_ep(3);
    for (int i = 0; i < 200; i++) begin
      if (bel_req) break;
      @(negedge clk);
    end
    chk("midrst_in_belief", longint'(bel_req), 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_zero("midrst");
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    chk("midrst_idle", longint'(busy), 0);

    // Clean episode after reset, then randomized episodes
    fix_dly = -1;
    start_ep(4);
    wait_done(300, nb);
    chk("post_rst_aborted", longint'(aborted), 0);
    for (int ep = 0; ep < 8; ep++) begin
      start_ep(int'($urandom_range(6, 1)));
      wait_done(400, nb);
    end

    repeat (3) @(negedge clk);
    chk("step_q_drained", longint'(step_q.size()), 0);
    chk("end_q_drained", longint'(end_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
